resultsign_pipe: RTL and testbench
==================================

# resultsign_pipe

Parametrised, pipelined, multi-lane result-sign unit for the FMA post-processing path. For each of `NLANES` lanes it picks the final sign of an FMA/multiply result from the infinity, zero-sum and normal-result cases. Results move through `STAGES` registers under a valid/ready handshake, so the unit can sit between a packed-SIMD FMA and the rounding/packing stage. It also reports, per lane, when the exact-cancellation zero rule was applied.

## Interface
Parameters:
- `NLANES`, default 4: number of independent sign lanes (1..8).
- `STAGES`, default 2: pipeline register depth (1..4); equals latency in cycles.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `InValid`  in  1  input transaction valid.
- `InReady`  out  1  unit can accept input this cycle.
- `Frm`  in  3  rounding mode, shared by all lanes of a transaction.
- `FmaOp`  in  1  transaction is an FMA-class operation.
- `Mult`  in  NLANES  per lane, operation is a plain multiply.
- `ZInf`  in  NLANES  per lane, addend is infinity.
- `InfIn`  in  NLANES  per lane, some input is infinity.
- `FmaSZero`  in  NLANES  per lane, FMA sum is zero.
- `Ms`  in  NLANES  per lane, normalized result sign.
- `FmaPs`  in  NLANES  per lane, product sign.
- `FmaAs`  in  NLANES  per lane, aligned addend sign.
- `Guard`, `Round`, `Sticky`  in  NLANES each  per-lane rounding bits.
- `OutValid`  out  1  output transaction valid.
- `OutReady`  in  1  downstream accepts output.
- `Rs`  out  NLANES  per-lane result sign.
- `CancelZero`  out  NLANES  per lane, exact-cancellation zero rule selected.
- `ZeroCntClr`  in  1  clear the cancellation counter.
- `ZeroCnt`  out  16  saturating cancellation-lane count.

## Operation
Per lane i, computed combinationally at the input and then registered:
- `exact_i = (FmaPs^FmaAs) & ~(Guard|Round|Sticky) & ~Mult`.
- `Zeros_i`: if `exact_i`, then `(Frm[1:0]==2'b10)`; otherwise `FmaPs`.
- `Infs_i`: if `ZInf`, then `FmaAs`; otherwise `FmaPs`.
- Priority for `Rs_i`:
  - `InfIn & FmaOp` gives `Infs_i`;
  - else `FmaSZero & FmaOp` gives `Zeros_i`;
  - else `Ms`.
- `CancelZero_i = FmaOp & ~InfIn & FmaSZero & exact_i`.

Lanes are fully independent; only `Frm` and `FmaOp` are shared.

Pipeline:
- Stage k holds a valid bit v[k] plus `Rs`/`CancelZero` vectors.
- adv[last] = ~v[last] | OutReady; adv[k] = ~v[k] | adv[k+1].
- `InReady = adv[0]`. Stage 0 loads `InValid` and the computed data when adv[0].
- Stage k+1 loads stage k when adv[k+1]. A stage does not change when it does not advance.
- `OutValid = v[last]`; `Rs`/`CancelZero` are driven from the last stage.
- The pipeline gives full throughput: one transaction per cycle while `OutReady` stays high. A stall back-propagates combinationally through `InReady`.
- Data registers load only on advance. Bubbles (`InValid=0`) carry valid=0 and leave data unchanged.

## Timing
- Latency is exactly `STAGES` cycles from the input handshake (`InValid & InReady`) to `OutValid`, when there are no stalls.
- Reset: all v[k]=0, data registers 0. Outputs after reset: `OutValid=0`, `Rs=0`, `CancelZero=0`, `ZeroCnt=0`, `InReady=1`.
- Reset mid-operation drops all in-flight transactions the next cycle; no output handshake occurs for them.
- When `OutValid=1 & OutReady=0`, `Rs` and `CancelZero` hold stable until accepted.
- Inputs are sampled only on the input handshake; input values in other cycles are ignored.
- Full pipeline with `OutReady` low: `InReady=0`. If `OutReady` rises, the same cycle shows `InReady=1`, and the output accept and input accept both happen on that edge.

## Configuration
- Macro `RESULTSIGN_ZEROCNT_EN`.
- Defined:
  - On each output handshake, `ZeroCnt` adds popcount(`CancelZero`) and saturates at 16'hFFFF.
  - `ZeroCntClr` is synchronous and has priority: it sets the counter to 0, and that cycle's increment is discarded.
- Undefined: no counter logic; `ZeroCnt` is tied to 16'h0 and `ZeroCntClr` is ignored.
- The sign datapath is identical in both builds.

## Test plan
- **Cancellation zero:** NLANES=4, STAGES=2. Lane0: FmaOp=1, FmaSZero=1, FmaPs=0, FmaAs=1, G/R/S=0, Mult=0; Frm=3'b010 then 3'b000. Required: Rs[0]=1 then 0, CancelZero[0]=1, output exactly 2 cycles after accept.
- **Inexact zero and infinities:** same as above but Sticky=1, giving Rs=FmaPs, CancelZero=0. InfIn=1, ZInf=1, FmaAs=1, FmaPs=0 gives Rs=1. InfIn=1, ZInf=0, FmaPs=1 gives Rs=1. FmaOp=0 with Ms=1 gives Rs=1.
- **Backpressure:** stream 6 transactions with OutReady low for cycles 3–6. Required: InReady=0 once both stages are full; outputs held stable; all 6 delivered in order with no loss or duplication.
- **Reset mid-stream:** assert reset with 2 transactions in flight. Required: next cycle OutValid=0 and ZeroCnt=0; no stale output appears afterwards.
- **Counter (macro defined):** 3 handshakes, each with CancelZero=4'b1011, give ZeroCnt=9. Preload near saturation, e.g. 16'hFFFE plus 3 lanes, gives 16'hFFFF. ZeroCntClr in the same cycle as a handshake gives 0.
- **Macro undefined:** repeat the counter scenario. Required: ZeroCnt stays 0 and Rs matches the defined build.

Source files
------------

// File: rtl/resultsign_pipe_if.sv
// Handshake and data bundle for the FMA result-sign pipeline: input transaction,
// output transaction and cancellation-counter controls.
interface resultsign_pipe_if #(
  parameter int NLANES = 4
);
  logic              InValid;
  logic              InReady;
  logic [2:0]        Frm;
  logic              FmaOp;
  logic [NLANES-1:0] Mult;
  logic [NLANES-1:0] ZInf;
  logic [NLANES-1:0] InfIn;
  logic [NLANES-1:0] FmaSZero;
  logic [NLANES-1:0] Ms;
  logic [NLANES-1:0] FmaPs;
  logic [NLANES-1:0] FmaAs;
  logic [NLANES-1:0] Guard;
  logic [NLANES-1:0] Round;
  logic [NLANES-1:0] Sticky;
  logic              OutValid;
  logic              OutReady;
  logic [NLANES-1:0] Rs;
  logic [NLANES-1:0] CancelZero;
  logic              ZeroCntClr;
  logic [15:0]       ZeroCnt;

  modport master (
    output InValid, Frm, FmaOp, Mult, ZInf, InfIn, FmaSZero, Ms, FmaPs, FmaAs,
           Guard, Round, Sticky, OutReady, ZeroCntClr,
    input  InReady, OutValid, Rs, CancelZero, ZeroCnt
  );

  modport slave (
    input  InValid, Frm, FmaOp, Mult, ZInf, InfIn, FmaSZero, Ms, FmaPs, FmaAs,
           Guard, Round, Sticky, OutReady, ZeroCntClr,
    output InReady, OutValid, Rs, CancelZero, ZeroCnt
  );
endinterface

// File: rtl/resultsign_pipe.sv
// Multi-lane FMA result-sign selection with a STAGES-deep valid/ready pipeline.
// Define RESULTSIGN_ZEROCNT_EN to build the saturating cancellation-lane counter.
module resultsign_pipe #(
  parameter int NLANES = 4,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  resultsign_pipe_if.slave  bus
);

  logic [NLANES-1:0] w_exact;
  logic [NLANES-1:0] w_zeros;
  logic [NLANES-1:0] w_infs;
  logic [NLANES-1:0] w_sel_inf;
  logic [NLANES-1:0] w_sel_zero;
  logic [NLANES-1:0] w_rs_p0;
  logic [NLANES-1:0] w_cz_p0;
  logic [NLANES-1:0] w_op;
  logic              w_rdn;

  // Sign selection: infinity beats zero-sum, zero-sum beats the normal result
  always_comb begin
    w_op       = {NLANES{bus.FmaOp}};
    w_rdn      = (bus.Frm[1:0] == 2'b10);
    w_exact    = (bus.FmaPs ^ bus.FmaAs) & ~(bus.Guard | bus.Round | bus.Sticky) & ~bus.Mult;
    w_zeros    = (w_exact & {NLANES{w_rdn}}) | (~w_exact & bus.FmaPs);
    w_infs     = (bus.ZInf & bus.FmaAs) | (~bus.ZInf & bus.FmaPs);
    w_sel_inf  = bus.InfIn & w_op;
    w_sel_zero = ~w_sel_inf & bus.FmaSZero & w_op;
    w_rs_p0    = (w_sel_inf & w_infs) | (w_sel_zero & w_zeros) |
                 (~w_sel_inf & ~w_sel_zero & bus.Ms);
    w_cz_p0    = w_op & ~bus.InfIn & bus.FmaSZero & w_exact;
  end

  logic [STAGES-1:0] r_vld_p;
  logic [NLANES-1:0] r_rs_p [STAGES];
  logic [NLANES-1:0] r_cz_p [STAGES];
  logic [STAGES-1:0] w_adv;

  // A stage advances when downstream accepts or any stage at or after it is empty
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_adv[k] = bus.OutReady | ((r_vld_p | STAGES'((1 << k) - 1)) != '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld_p[k] <= 1'b0;
        r_rs_p[k]  <= '0;
        r_cz_p[k]  <= '0;
      end
    end else begin
      // stage 0: capture from the input on handshake
      if (w_adv[0]) begin
        r_vld_p[0] <= bus.InValid;
        if (bus.InValid) begin
          r_rs_p[0] <= w_rs_p0;
          r_cz_p[0] <= w_cz_p0;
        end
      end
      // stages 1..STAGES-1: shift forward, bubbles leave data untouched
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld_p[k] <= r_vld_p[k-1];
          if (r_vld_p[k-1]) begin
            r_rs_p[k] <= r_rs_p[k-1];
            r_cz_p[k] <= r_cz_p[k-1];
          end
        end
      end
    end
  end

  assign bus.InReady    = w_adv[0];
  assign bus.OutValid   = r_vld_p[STAGES-1];
  assign bus.Rs         = r_rs_p[STAGES-1];
  assign bus.CancelZero = r_cz_p[STAGES-1];

  logic w_unused;

`ifdef RESULTSIGN_ZEROCNT_EN
  function automatic logic [4:0] popcount(input logic [NLANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NLANES; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] r_zcnt;

  // Clear wins over a same-cycle output handshake
  always_ff @(posedge clk) begin
    if (reset || bus.ZeroCntClr) begin
      r_zcnt <= '0;
    end else if (bus.OutValid && bus.OutReady) begin
      r_zcnt <= sat_add16(r_zcnt, popcount(r_cz_p[STAGES-1]));
    end
  end

  assign bus.ZeroCnt = r_zcnt;
  assign w_unused    = bus.Frm[2];
`else
  assign bus.ZeroCnt = 16'h0;
  assign w_unused    = bus.Frm[2] ^ bus.ZeroCntClr;
`endif

endmodule

// File: tb/tb_resultsign_pipe.sv
// Bench for resultsign_pipe: lane-rule reference model with an in-order scoreboard
// checked every cycle, plus directed vectors with hand-computed literals.
module tb_resultsign_pipe;
  localparam int NL = 4;
  localparam int ST = 2;

  typedef struct packed {
    logic [2:0]    frm;
    logic          op;
    logic [NL-1:0] mult, zinf, infin, sz, ms, ps, as_, g, r, s;
  } txn_t;

  typedef struct packed {
    logic [NL-1:0] rs;
    logic [NL-1:0] cz;
    int            acc;
  } exp_t;

`ifdef RESULTSIGN_ZEROCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dut_pops = 0;
  bit   chk_en = 1'b0;
  exp_t q[$];
  logic [15:0] mcnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  resultsign_pipe_if #(.NLANES(NL)) bus ();
  resultsign_pipe #(.NLANES(NL), .STAGES(ST)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane rules written per lane from the sign-selection definition
  function automatic void ref_sign(input txn_t t, output logic [NL-1:0] rs, output logic [NL-1:0] cz);
    bit exact, zs, is_;
    for (int i = 0; i < NL; i++) begin
      exact = (t.ps[i] != t.as_[i]) && !(t.g[i] || t.r[i] || t.s[i]) && !t.mult[i];
      zs    = exact ? (t.frm[1:0] == 2'b10) : t.ps[i];
      is_   = t.zinf[i] ? t.as_[i] : t.ps[i];
      if (t.op && t.infin[i])   rs[i] = is_;
      else if (t.op && t.sz[i]) rs[i] = zs;
      else                      rs[i] = t.ms[i];
      cz[i] = t.op && !t.infin[i] && t.sz[i] && exact;
    end
  endfunction

  function automatic txn_t cur_txn();
    txn_t t;
    t.frm = bus.Frm;      t.op = bus.FmaOp;     t.mult = bus.Mult;
    t.zinf = bus.ZInf;    t.infin = bus.InfIn;  t.sz = bus.FmaSZero;
    t.ms = bus.Ms;        t.ps = bus.FmaPs;     t.as_ = bus.FmaAs;
    t.g = bus.Guard;      t.r = bus.Round;      t.s = bus.Sticky;
    return t;
  endfunction

  // Every-cycle compare against the scoreboard, then apply this cycle's handshakes
  always @(negedge clk) begin
    bit   exp_ov, exp_ir;
    int   sum;
    exp_t e;
    if (chk_en) begin
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= ST);
      exp_ir = bus.OutReady || (q.size() < ST);
      chk("OutValid", bus.OutValid, exp_ov);
      chk("InReady", bus.InReady, exp_ir);
      if (exp_ov) begin
        chk("Rs", bus.Rs, q[0].rs);
        chk("CancelZero", bus.CancelZero, q[0].cz);
      end
      chk("ZeroCnt", bus.ZeroCnt, mcnt);
      if (bus.OutValid && bus.OutReady) dut_pops++;
      if (reset) begin
        q.delete();
        mcnt = '0;
      end else begin
        if (exp_ov && bus.OutReady) begin
          e = q.pop_front();
          if (CNT_EN) begin
            sum  = int'(mcnt) + $countones(e.cz);
            mcnt = (sum > 65535) ? 16'hFFFF : 16'(sum);
          end
        end
        if (CNT_EN && bus.ZeroCntClr) mcnt = '0;
        if (bus.InValid && exp_ir) begin
          ref_sign(cur_txn(), e.rs, e.cz);
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  function automatic txn_t zero_txn();
    txn_t t;
    t = '0;
    return t;
  endfunction

  // Lanes in m cancel exactly; the rest are exact-sum zeros with equal signs
  function automatic txn_t cz_txn(input logic [NL-1:0] m);
    txn_t t;
    t     = zero_txn();
    t.op  = 1'b1;
    t.sz  = '1;
    t.as_ = m;
    return t;
  endfunction

  task automatic apply(input txn_t t);
    bus.Frm = t.frm;      bus.FmaOp = t.op;     bus.Mult = t.mult;
    bus.ZInf = t.zinf;    bus.InfIn = t.infin;  bus.FmaSZero = t.sz;
    bus.Ms = t.ms;        bus.FmaPs = t.ps;     bus.FmaAs = t.as_;
    bus.Guard = t.g;      bus.Round = t.r;      bus.Sticky = t.s;
  endtask

  task automatic send1(input txn_t t, output logic [NL-1:0] rs, output logic [NL-1:0] cz,
                       output int lat);
    apply(t);
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    lat = 1;
    rs  = '0;
    cz  = '0;
    forever begin
      @(negedge clk);
      if (bus.OutValid) break;
      if (lat >= 20) begin
        chk("send1_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    rs = bus.Rs;
    cz = bus.CancelZero;
    @(posedge clk); #1;
  endtask

  task automatic stream_cz(input logic [NL-1:0] m, input int n);
    bus.OutReady = 1'b1;
    apply(cz_txn(m));
    bus.InValid = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.InValid = 1'b0;
    repeat (ST + 2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t          t;
    txn_t          bp [6];
    logic [NL-1:0] rs, cz;
    int            lat, idx, pops0;

    apply(zero_txn());
    bus.InValid    = 1'b0;
    bus.OutReady   = 1'b1;
    bus.ZeroCntClr = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_Rs", bus.Rs, 0);
    chk("rst_CancelZero", bus.CancelZero, 0);
    chk("rst_InReady", bus.InReady, 1);
    chk("rst_OutValid", bus.OutValid, 0);
    chk("rst_ZeroCnt", bus.ZeroCnt, 0);
    @(posedge clk); #1;

    // Exact cancellation, round-down then round-to-nearest
    t = zero_txn(); t.op = 1'b1; t.sz[0] = 1'b1; t.as_[0] = 1'b1; t.frm = 3'b010;
    send1(t, rs, cz, lat);
    chk("cancel_rdn_rs0", rs[0], 1);
    chk("cancel_rdn_cz0", cz[0], 1);
    chk("cancel_latency", lat, 2);
    t.frm = 3'b000;
    send1(t, rs, cz, lat);
    chk("cancel_rne_rs0", rs[0], 0);
    chk("cancel_rne_cz0", cz[0], 1);
    // Inexact zero keeps the product sign
    t.frm = 3'b010; t.s[0] = 1'b1;
    send1(t, rs, cz, lat);
    chk("inexact_rs0", rs[0], 0);
    chk("inexact_cz0", cz[0], 0);
    // Plain multiply never uses the cancellation rule
    t = zero_txn(); t.op = 1'b1; t.sz[0] = 1'b1; t.as_[0] = 1'b1; t.frm = 3'b010; t.mult[0] = 1'b1;
    send1(t, rs, cz, lat);
    chk("mult_rs0", rs[0], 0);
    chk("mult_cz0", cz[0], 0);
    // Infinity cases
    t = zero_txn(); t.op = 1'b1; t.infin[0] = 1'b1; t.zinf[0] = 1'b1; t.as_[0] = 1'b1;
    send1(t, rs, cz, lat);
    chk("inf_addend_rs0", rs[0], 1);
    t = zero_txn(); t.op = 1'b1; t.infin[0] = 1'b1; t.ps[0] = 1'b1; t.sz[0] = 1'b1;
    send1(t, rs, cz, lat);
    chk("inf_prod_rs0", rs[0], 1);
    chk("inf_prod_cz0", cz[0], 0);
    // Non-FMA: normal sign regardless of inf/zero flags
    t = zero_txn(); t.ms = 4'b0101; t.infin[0] = 1'b1; t.sz[0] = 1'b1; t.ps = 4'b1010;
    send1(t, rs, cz, lat);
    chk("nonfma_rs", rs, 4'b0101);

    // Backpressure: 6 transactions, OutReady low for cycles 3..6
    for (int i = 0; i < 6; i++) begin
      bp[i]    = zero_txn();
      bp[i].ms = NL'(i + 1);
    end
    idx   = 0;
    pops0 = dut_pops;
    for (int c = 0; c < 20; c++) begin
      bus.OutReady = !(c >= 3 && c <= 6);
      if (idx < 6) begin
        apply(bp[idx]);
        bus.InValid = 1'b1;
      end else begin
        bus.InValid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("bp_inready_full", bus.InReady, 0);
        chk("bp_hold_rs", bus.Rs, 4'd2);
      end
      if (bus.InValid && bus.InReady) idx++;
      @(posedge clk); #1;
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    chk("bp_accepted", idx, 6);
    chk("bp_delivered", dut_pops - pops0, 6);

    // Counter: 3 x 4'b1011
    bus.ZeroCntClr = 1'b1;
    @(posedge clk); #1;
    bus.ZeroCntClr = 1'b0;
    stream_cz(4'b1011, 3);
    @(negedge clk);
    chk("cnt_3x1011", bus.ZeroCnt, CNT_EN ? 9 : 0);
    @(posedge clk); #1;
    // Climb to 16'hFFFE, then saturate
    bus.ZeroCntClr = 1'b1;
    @(posedge clk); #1;
    bus.ZeroCntClr = 1'b0;
    stream_cz(4'b1111, 16383);
    stream_cz(4'b0011, 1);
    @(negedge clk);
    chk("cnt_fffe", bus.ZeroCnt, CNT_EN ? 16'hFFFE : 0);
    @(posedge clk); #1;
    stream_cz(4'b1011, 1);
    @(negedge clk);
    chk("cnt_saturate", bus.ZeroCnt, CNT_EN ? 16'hFFFF : 0);
    @(posedge clk); #1;
    // Clear in the same cycle as the output handshake
    apply(cz_txn(4'b1011));
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    @(posedge clk); #1;
    bus.ZeroCntClr = 1'b1;
    @(negedge clk);
    chk("clr_hs_outvalid", bus.OutValid, 1);
    @(posedge clk); #1;
    bus.ZeroCntClr = 1'b0;
    @(negedge clk);
    chk("clr_with_handshake", bus.ZeroCnt, 0);
    @(posedge clk); #1;

    // Reset with two transactions in flight
    stream_cz(4'b1011, 1);
    pops0        = dut_pops;
    bus.OutReady = 1'b0;
    apply(cz_txn(4'b1011));
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_outvalid", bus.OutValid, 0);
    chk("rst_mid_zerocnt", bus.ZeroCnt, 0);
    @(posedge clk); #1;
    bus.OutReady = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_no_stale", dut_pops - pops0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
